// File: rtl/comm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comm_pkg
//  Description : Shared definitions for the memory-to-UART streaming path:
//                tx_streamer state encoding and the common address/byte widths
//                used by control and memory blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package comm_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int BYTE_W         = 8;

    // ST_CSUM is only reachable when the trailing checksum byte is enabled.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_SEND    = 3'd3,
        ST_GUARD   = 3'd4,
        ST_WAIT_TX = 3'd5,
        ST_FINISH  = 3'd6,
        ST_CSUM    = 3'd7
    } tx_state_e;

endpackage : comm_pkg
`default_nettype wire

// File: rtl/tx_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tx_streamer
//  Description : Streams `length` bytes of main memory starting at base_addr
//                out through async_transmitter, one byte per UART frame, and
//                pulses done when finished.
//                Optional build macro TX_CHECKSUM_EN appends an 8-bit modular
//                sum of the payload as one extra trailing byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_streamer
    import comm_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = BYTE_W,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] readPtr,
    input  logic [DATA_W-1:0] rdata,
    output logic              TxD_start,
    output logic [DATA_W-1:0] TxD_data,
    input  logic              TxD_busy,
    output logic              busy,
    output logic              done
);

    // Latency counter is wide enough for the legal MEM_LATENCY range 1..4.
    localparam int               LAT_W    = 3;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

    tx_state_e         state_q,     state_d;
    logic [ADDR_W-1:0] read_ptr_q,  read_ptr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [LAT_W-1:0]  lat_cnt_q,   lat_cnt_d;
    logic [DATA_W-1:0] tx_data_q,   tx_data_d;
    logic              tx_start_q,  tx_start_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
`ifdef TX_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q,       sum_d;
    logic              csum_sent_q, csum_sent_d;
`endif

    // Next-state logic for the streaming FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        read_ptr_d  = read_ptr_q;
        remaining_d = remaining_q;
        lat_cnt_d   = lat_cnt_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        busy_d      = busy_q;
`ifdef TX_CHECKSUM_EN
        sum_d       = sum_q;
        csum_sent_d = csum_sent_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef TX_CHECKSUM_EN
                    sum_d       = '0;
                    csum_sent_d = 1'b0;
`endif
                    if (length != '0) begin
                        read_ptr_d  = base_addr;
                        remaining_d = length;
                        lat_cnt_d   = '0;
                        busy_d      = 1'b1;
                        state_d     = ST_FETCH;
                    end else begin
`ifdef TX_CHECKSUM_EN
                        // Empty payload still carries its (zero) checksum.
                        remaining_d = '0;
                        busy_d      = 1'b1;
                        state_d     = ST_CSUM;
`else
                        state_d     = ST_FINISH;
`endif
                    end
                end
            end
            ST_FETCH: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            ST_LOAD: begin
                tx_data_d = rdata;
`ifdef TX_CHECKSUM_EN
                sum_d     = sum_q + rdata;
`endif
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (!TxD_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = ST_GUARD;
                end
            end
            ST_GUARD: begin
                // Transmitter busy rises a cycle after it sees TxD_start.
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (!TxD_busy) begin
`ifdef TX_CHECKSUM_EN
                    if (csum_sent_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        remaining_d = remaining_q - ADDR_W'(1);
                        if (remaining_q == ADDR_W'(1)) begin
                            state_d = ST_CSUM;
                        end else begin
                            read_ptr_d = read_ptr_q + ADDR_W'(1);
                            lat_cnt_d  = '0;
                            state_d    = ST_FETCH;
                        end
                    end
`else
                    remaining_d = remaining_q - ADDR_W'(1);
                    if (remaining_q == ADDR_W'(1)) begin
                        state_d = ST_FINISH;
                    end else begin
                        read_ptr_d = read_ptr_q + ADDR_W'(1);
                        lat_cnt_d  = '0;
                        state_d    = ST_FETCH;
                    end
`endif
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
`ifdef TX_CHECKSUM_EN
            ST_CSUM: begin
                tx_data_d   = sum_q;
                csum_sent_d = 1'b1;
                state_d     = ST_SEND;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // done is high exactly for the cycle spent in FINISH.
        done_d = (state_d == ST_FINISH);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            read_ptr_q  <= '0;
            remaining_q <= '0;
            lat_cnt_q   <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef TX_CHECKSUM_EN
            sum_q       <= '0;
            csum_sent_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            read_ptr_q  <= read_ptr_d;
            remaining_q <= remaining_d;
            lat_cnt_q   <= lat_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef TX_CHECKSUM_EN
            sum_q       <= sum_d;
            csum_sent_q <= csum_sent_d;
`endif
        end
    end

    assign readPtr   = read_ptr_q;
    assign TxD_start = tx_start_q;
    assign TxD_data  = tx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : tx_streamer
`default_nettype wire

// File: tb/tb_tx_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_streamer
//  Description : Self-checking bench for tx_streamer with a byte memory model,
//                a simple UART transmitter model and a byte scoreboard.
//                Honours TX_CHECKSUM_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_streamer;

    localparam int MEM_LATENCY = 1;
    localparam int FRAME       = 10;
    localparam int BUDGET      = 2000;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        chk_addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] length = '0;
    logic [15:0] readPtr;
    logic [7:0]  rdata;
    logic        TxD_start;
    logic [7:0]  TxD_data;
    logic        TxD_busy;
    logic        busy;
    logic        done;

    int   total = 0;
    int   bad = 0;
    int   tx_count = 0;
    int   done_cnt = 0;
    int   frame_cnt = 0;
    logic ext_hold = 1'b0;
    exp_t sb[$];
    logic [7:0] mem [0:65535];
    logic [7:0] rd_pipe [MEM_LATENCY];

    tx_streamer #(.ADDR_W(16), .DATA_W(8), .MEM_LATENCY(MEM_LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .readPtr   (readPtr),
        .rdata     (rdata),
        .TxD_start (TxD_start),
        .TxD_data  (TxD_data),
        .TxD_busy  (TxD_busy),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Memory read port with MEM_LATENCY cycles of latency.
    always @(posedge clk) begin
        rd_pipe[0] <= mem[readPtr];
        for (int i = 1; i < MEM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rdata = rd_pipe[MEM_LATENCY-1];

    // Transmitter model: busy for FRAME cycles after accepting a start.
    always @(posedge clk) begin
        if (frame_cnt != 0)  frame_cnt <= frame_cnt - 1;
        else if (TxD_start)  frame_cnt <= FRAME;
    end
    assign TxD_busy = (frame_cnt != 0) || ext_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: each transmitted byte is matched against the queue.
    always @(negedge clk) begin
        if (TxD_start) begin
            exp_t e;
            tx_count++;
            check("txstart_while_busy", {31'd0, TxD_busy}, 32'd0);
            check("tx_expected_pending", {31'd0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("tx_data", {24'd0, TxD_data}, {24'd0, e.data});
                if (e.chk_addr) check("tx_addr", {16'd0, readPtr}, {16'd0, e.addr});
            end
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [15:0] a, input logic [7:0] d, input logic ca);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.chk_addr = ca;
        sb.push_back(e);
    endtask

    // Expected bytes of a stream, plus the trailing checksum when enabled.
    task automatic push_stream(input logic [15:0] b, input int n);
        logic [7:0]  s;
        logic [15:0] a;
        s = 8'h00;
        for (int i = 0; i < n; i++) begin
            a = b + 16'(i);
            push_byte(a, mem[a], 1'b1);
            s = s + mem[a];
        end
`ifdef TX_CHECKSUM_EN
        push_byte(16'h0, s, 1'b0);
`endif
    endtask

    task automatic issue_start(input logic [15:0] b, input logic [15:0] n);
        base_addr = b;
        length    = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Wait for done, checking that busy stays high until it arrives.
    task automatic wait_done(input string tag);
        int busy_low;
        bit seen;
        busy_low = 0;
        seen = 0;
        for (int i = 0; i < BUDGET; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (!busy) busy_low++;
            tick();
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_busy_held"}, busy_low, 0);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < BUDGET; i++) begin
            if (!TxD_busy && !busy) break;
            tick();
        end
        tick();
    endtask

    initial begin
        int tx0;
        int dn0;
        bit seen;

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);

        // Reset values
        reset = 1'b1;
        repeat (3) tick();
        check("rst_readPtr",   {16'd0, readPtr}, 32'd0);
        check("rst_TxD_start", {31'd0, TxD_start}, 32'd0);
        check("rst_TxD_data",  {24'd0, TxD_data}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_done",      {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic stream with latency checks
        mem[16'h0100] = 8'hA5; mem[16'h0101] = 8'h3C;
        mem[16'h0102] = 8'hFF; mem[16'h0103] = 8'h00;
        push_stream(16'h0100, 4);
        dn0 = done_cnt;
        issue_start(16'h0100, 16'd4);
        check("basic_readPtr_c1", {16'd0, readPtr}, 32'h0100);
        check("basic_busy_c1",    {31'd0, busy}, 32'd1);
        tick();
        tick();
        check("basic_data_c2",    {24'd0, TxD_data}, 32'hA5);
        check("basic_start_lo_c2",{31'd0, TxD_start}, 32'd0);
        tick();
        check("basic_start_c3",   {31'd0, TxD_start}, 32'd1);
        wait_done("basic");
        repeat (3) tick();
        check("basic_done_once", done_cnt - dn0, 1);
        check("basic_busy_after", {31'd0, busy}, 32'd0);
        wait_idle();

        // Zero length
        tx0 = tx_count;
        dn0 = done_cnt;
`ifdef TX_CHECKSUM_EN
        push_byte(16'h0, 8'h00, 1'b0);
        issue_start(16'h0200, 16'd0);
        wait_done("zero");
        repeat (3) tick();
        check("zero_tx_count", tx_count - tx0, 1);
`else
        issue_start(16'h0200, 16'd0);
        check("zero_done_c1", {31'd0, done}, 32'd1);
        check("zero_busy_c1", {31'd0, busy}, 32'd0);
        tick();
        check("zero_done_c2", {31'd0, done}, 32'd0);
        repeat (5) tick();
        check("zero_tx_count", tx_count - tx0, 0);
`endif
        check("zero_done_once", done_cnt - dn0, 1);
        wait_idle();

        // Address wrap-around
        mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33;
        push_stream(16'hFFFE, 3);
        issue_start(16'hFFFE, 16'd3);
        wait_done("wrap");
        wait_idle();

        // Back-pressure at first SEND, plus a start while busy
        tx0 = tx_count;
        dn0 = done_cnt;
        push_stream(16'h0200, 2);
        ext_hold = 1'b1;
        issue_start(16'h0200, 16'd2);
        for (int i = 0; i < 200; i++) begin
            if (i == 50) begin
                base_addr = 16'h0300;
                length    = 16'd5;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("bp_no_start_held", tx_count - tx0, 0);
        ext_hold = 1'b0;
        tick();
        check("bp_start_after_release", {31'd0, TxD_start}, 32'd1);
        wait_done("bp");
        repeat (3) tick();
`ifdef TX_CHECKSUM_EN
        check("bp_byte_count", tx_count - tx0, 3);
`else
        check("bp_byte_count", tx_count - tx0, 2);
`endif
        check("bp_done_once", done_cnt - dn0, 1);
        wait_idle();

        // Reset in the middle of a 5-byte stream
        tx0 = tx_count;
        push_byte(16'h0400, mem[16'h0400], 1'b1);
        push_byte(16'h0401, mem[16'h0401], 1'b1);
        issue_start(16'h0400, 16'd5);
        seen = 0;
        for (int i = 0; i < BUDGET; i++) begin
            if (tx_count - tx0 >= 2) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("mid_second_byte_seen", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_TxD_start", {31'd0, TxD_start}, 32'd0);
        check("mid_rst_busy",      {31'd0, busy}, 32'd0);
        check("mid_rst_readPtr",   {16'd0, readPtr}, 32'd0);
        check("mid_sb_empty",      sb.size(), 0);
        wait_idle();
        mem[16'h0010] = 8'h5A; mem[16'h0011] = 8'hC3;
        push_stream(16'h0010, 2);
        issue_start(16'h0010, 16'd2);
        wait_done("after_rst");
        wait_idle();

`ifdef TX_CHECKSUM_EN
        // Checksum wraps modulo 256: 0x80+0x90+0x01 = 0x111 -> 0x11
        mem[16'h0500] = 8'h80; mem[16'h0501] = 8'h90; mem[16'h0502] = 8'h01;
        push_byte(16'h0500, 8'h80, 1'b1);
        push_byte(16'h0501, 8'h90, 1'b1);
        push_byte(16'h0502, 8'h01, 1'b1);
        push_byte(16'h0, 8'h11, 1'b0);
        issue_start(16'h0500, 16'd3);
        wait_done("csum");
        wait_idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tx_streamer
`default_nettype wire

// File: doc/tx_streamer.md
Name: tx_streamer

Overview:
- Drains a contiguous byte region of the main memory out over the UART.
- Sits between the memory read port (readPtr/outData) and async_transmitter (TxD_start/TxD_data/TxD_busy).
- Started by a host-to-device request pulse (device2host). Sends `length` bytes from `base_addr`, one byte per transmitter frame, then pulses done.

Parameters:
- ADDR_W, 16, width of memory address, length and byte counter.
- DATA_W, 8, byte width (UART payload).
- MEM_LATENCY, 1, memory read latency in clocks, from readPtr to valid rdata; legal range 1..4.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin streaming; sampled only in IDLE
- base_addr  input  ADDR_W  first memory address; latched on accepted start
- length  input  ADDR_W  number of payload bytes; latched on accepted start
- readPtr  output  ADDR_W  memory read address (registered)
- rdata  input  DATA_W  memory read data
- TxD_start  output  1  one-cycle strobe to async_transmitter
- TxD_data  output  DATA_W  byte to transmit; stable from TxD_start until next load
- TxD_busy  input  1  transmitter busy flag
- busy  output  1  high while a stream is in progress
- done  output  1  one-cycle pulse when stream completes

Behaviour:
- Reset (sync, active-high): state=IDLE; readPtr=0, TxD_start=0, TxD_data=0, busy=0, done=0; internal counters=0.
- Reset mid-stream aborts on the next edge. TxD_start drops. A frame already inside the transmitter finishes on its own and is not tracked.
- FSM states: IDLE, FETCH, LOAD, SEND, GUARD, WAIT_TX, FINISH.
- IDLE, start=1, length!=0: latch base_addr and length; readPtr<=base_addr; remaining<=length; busy<=1; go FETCH.
- IDLE, start=1, length==0: go FINISH. No memory read, no TxD_start.
- start while busy=1 is ignored.
- FETCH: wait MEM_LATENCY cycles (latency counter), then go LOAD.
- LOAD: TxD_data<=rdata; go SEND.
- SEND: if TxD_busy==0, assert TxD_start for exactly one cycle and go GUARD; otherwise hold in SEND with TxD_start=0.
- GUARD: one cycle in which TxD_busy is ignored, covering the transmitter's registered busy rise; go WAIT_TX.
- WAIT_TX: wait for TxD_busy==0, then remaining<=remaining-1.
  - If remaining==1: go FINISH.
  - Otherwise: readPtr<=readPtr+1, wrapping modulo 2^ADDR_W (0xFFFF -> 0x0000); go FETCH.
- FINISH: done=1 for one cycle; busy<=0; go IDLE. A start in the FINISH cycle is ignored.
- Latency, MEM_LATENCY=1, TxD_busy low: start sampled at cycle 0; readPtr valid at cycle 1; TxD_data loaded at cycle 2; TxD_start high at cycle 3.
- Throughput: one byte per transmitter frame plus (MEM_LATENCY+3) cycles of overhead.
- readPtr changes only in IDLE (on accepted start) and in WAIT_TX.
- TxD_start is never asserted when TxD_busy=1.

Optional Feature:
- Macro: TX_CHECKSUM_EN
- Defined:
  - An 8-bit modular sum of all transmitted payload bytes is accumulated; cleared on accepted start.
  - After the last payload byte, WAIT_TX goes to a CSUM state: TxD_data<=sum, then SEND/GUARD/WAIT_TX run once more; FINISH follows.
  - length==0 sends a single checksum byte 0x00 before done.
- Undefined: no CSUM state, no accumulator; exactly `length` bytes are sent.

Decomposition:
- Shared package comm_pkg holds:
  - typedef enum for the tx_streamer states;
  - localparams DEFAULT_ADDR_W=16 and BYTE_W=8, shared with control and memory.
- No sub-module. The latency counter and the byte counter are plain registers in this block.

Test Plan:
- Reset mid-stream: pulse reset at byte 2 of 5 -> next cycle TxD_start=0, busy=0, readPtr=0, state IDLE; a following start with base=0x0010, length=2 sends 0x0010/0x0011 cleanly.
- Basic stream: memory[0x0100..0x0103]={0xA5,0x3C,0xFF,0x00}; start with base=0x0100, length=4 -> UART model receives A5,3C,FF,00 in order; done pulses once; busy high throughout; TxD_start at cycle 3 after start (MEM_LATENCY=1).
- Wrap-around: base=0xFFFE, length=3 -> reads addresses 0xFFFE, 0xFFFF, 0x0000.
- Zero length: start with length=0 -> done pulses at cycle 1; TxD_start never asserts (with TX_CHECKSUM_EN: one byte 0x00 is sent).
- Back-pressure and ignored start: hold TxD_busy=1 externally for 200 cycles at the first SEND -> TxD_start stays low; it asserts one cycle after TxD_busy falls. A second start issued while busy -> no effect on the byte count.
- Checksum (TX_CHECKSUM_EN): bytes {0x80,0x90,0x01} -> fourth byte transmitted is 0x11; done pulses after that byte.
